// File: rtl/prog_tick_counter.sv
// prog_tick_counter: programmable-rate up/down counter with wrap detection.
// A single down-counting divider produces step strobes at one of five
// selectable rates. Each step moves the count up or down, wrapping between
// 0 and CNT_MAX. The outputs are registered pulses that mark each step and
// each wrap.
module prog_tick_counter #(
    parameter int unsigned CNT_WIDTH = 7,
    parameter int unsigned CNT_MAX   = 100,
    parameter int unsigned DIV_WIDTH = 28,
    parameter int unsigned PERIOD0   = 1,
    parameter int unsigned PERIOD1   = 50000000,
    parameter int unsigned PERIOD2   = 25000000,
    parameter int unsigned PERIOD3   = 12500000,
    parameter int unsigned PERIOD4   = 5000000
) (
    input  logic                 CLOCK_50,
    input  logic                 resetn,
    input  logic [2:0]           clk_speed,
    input  logic                 run,
    input  logic                 dir,
    input  logic                 load,
    input  logic [CNT_WIDTH-1:0] load_value,
    output logic [CNT_WIDTH-1:0] current_number,
    output logic                 tick,
    output logic                 wrap
);

    // Wrap value at counter width. The divider reload values are one less
    // than the period, because the divider counts down to zero inclusive.
    localparam logic [CNT_WIDTH-1:0] MAX_VAL = CNT_WIDTH'(CNT_MAX);
    localparam logic [DIV_WIDTH-1:0] RELOAD0 = DIV_WIDTH'(PERIOD0 - 1);
    localparam logic [DIV_WIDTH-1:0] RELOAD1 = DIV_WIDTH'(PERIOD1 - 1);
    localparam logic [DIV_WIDTH-1:0] RELOAD2 = DIV_WIDTH'(PERIOD2 - 1);
    localparam logic [DIV_WIDTH-1:0] RELOAD3 = DIV_WIDTH'(PERIOD3 - 1);
    localparam logic [DIV_WIDTH-1:0] RELOAD4 = DIV_WIDTH'(PERIOD4 - 1);
    localparam logic [2:0]           SEL_LAST = 3'd4;

    // Maps a rate select to its divider reload value. Selects 5..7 are
    // invalid and map to 0, so the divider parks at 0 and stays there.
    function automatic logic [DIV_WIDTH-1:0] reloadFor(input logic [2:0] sel);
        logic [DIV_WIDTH-1:0] value;
        case (sel)
            3'd0:    value = RELOAD0;
            3'd1:    value = RELOAD1;
            3'd2:    value = RELOAD2;
            3'd3:    value = RELOAD3;
            3'd4:    value = RELOAD4;
            default: value = '0;
        endcase
        return value;
    endfunction

    logic [DIV_WIDTH-1:0] div_cnt_q, div_cnt_d;
    logic [2:0]           sel_q, sel_d;
    logic [CNT_WIDTH-1:0] count_q, count_d;
    logic                 tick_q, tick_d;
    logic                 wrap_q, wrap_d;

    logic                 speedChange;
    logic                 selValid;
    logic                 divZero;
    logic                 stepStrobe;

    // Step qualification. A change of rate select takes the whole cycle and
    // suppresses stepping. An invalid select never steps.
    always_comb begin
        speedChange = (clk_speed != sel_q);
        selValid    = (sel_q <= SEL_LAST);
        divZero     = (div_cnt_q == '0);
        stepStrobe  = run && !speedChange && selValid && divZero;
    end

    // Divider and select next state. A rate change restarts the divider at
    // the full period of the new rate. A step reloads it for the current
    // rate. While paused, the divider holds its partial period so that
    // counting resumes where it stopped.
    always_comb begin
        sel_d     = sel_q;
        div_cnt_d = div_cnt_q;
        if (speedChange) begin
            sel_d     = clk_speed;
            div_cnt_d = reloadFor(clk_speed);
        end else if (stepStrobe) begin
            div_cnt_d = reloadFor(sel_q);
        end else if (run && selValid && !divZero) begin
            div_cnt_d = div_cnt_q - DIV_WIDTH'(1);
        end
    end

    // Count next state. A load overrides any step in the same cycle and
    // clamps the loaded value to CNT_MAX. The wrap test uses >= and >, so an
    // out-of-range count cannot occur even in the unreachable case. The tick
    // follows the step strobe whether or not a load took over the count.
    always_comb begin
        count_d = count_q;
        tick_d  = stepStrobe;
        wrap_d  = 1'b0;
        if (load) begin
            count_d = (load_value > MAX_VAL) ? MAX_VAL : load_value;
        end else if (stepStrobe) begin
            if (!dir) begin
                if (count_q >= MAX_VAL) begin
                    count_d = '0;
                    wrap_d  = 1'b1;
                end else begin
                    count_d = count_q + CNT_WIDTH'(1);
                end
            end else begin
                if (count_q == '0) begin
                    count_d = MAX_VAL;
                    wrap_d  = 1'b1;
                end else if (count_q > MAX_VAL) begin
                    count_d = MAX_VAL;
                end else begin
                    count_d = count_q - CNT_WIDTH'(1);
                end
            end
        end
    end

    // State registers. Reset clears everything, including the divider, so a
    // period that is in progress is discarded.
    always_ff @(posedge CLOCK_50 or negedge resetn) begin
        if (!resetn) begin
            div_cnt_q <= '0;
            sel_q     <= '0;
            count_q   <= '0;
            tick_q    <= 1'b0;
            wrap_q    <= 1'b0;
        end else begin
            div_cnt_q <= div_cnt_d;
            sel_q     <= sel_d;
            count_q   <= count_d;
            tick_q    <= tick_d;
            wrap_q    <= wrap_d;
        end
    end

    assign current_number = count_q;
    assign tick           = tick_q;
    assign wrap           = wrap_q;

endmodule

// File: tb/tb_prog_tick_counter.sv
// Directed testbench for prog_tick_counter. It uses short periods so that
// every rate can be exercised in a few cycles.
module tb_prog_tick_counter;

    logic       CLOCK_50 = 1'b0;
    logic       resetn;
    logic [2:0] clk_speed;
    logic       run;
    logic       dir;
    logic       load;
    logic [6:0] load_value;
    logic [6:0] current_number;
    logic       tick;
    logic       wrap;

    int assertCount = 0;
    int failCount   = 0;

    prog_tick_counter #(
        .CNT_WIDTH(7), .CNT_MAX(100), .DIV_WIDTH(28),
        .PERIOD0(1), .PERIOD1(4), .PERIOD2(6), .PERIOD3(3), .PERIOD4(2)
    ) dut (
        .CLOCK_50(CLOCK_50),
        .resetn(resetn),
        .clk_speed(clk_speed),
        .run(run),
        .dir(dir),
        .load(load),
        .load_value(load_value),
        .current_number(current_number),
        .tick(tick),
        .wrap(wrap)
    );

    always #5 CLOCK_50 = ~CLOCK_50;

    // Advance one rising edge and settle just after it.
    task automatic cycle();
        @(posedge CLOCK_50);
        #1;
    endtask

    task automatic test_reset();
        resetn = 1'b1; clk_speed = 3'd0; run = 1'b1; dir = 1'b0;
        load = 1'b0; load_value = '0;
        #1 resetn = 1'b0;
        #1;
        assertCount++;
        if (current_number !== 7'd0 || tick !== 1'b0 || wrap !== 1'b0) begin
            failCount++;
            $display("[TB] FAIL reset_async: cur=%0d tick=%b wrap=%b expected 0/0/0", current_number, tick, wrap);
        end
        cycle();
        cycle();
        assertCount++;
        if (current_number !== 7'd0 || tick !== 1'b0 || wrap !== 1'b0) begin
            failCount++;
            $display("[TB] FAIL reset_held: cur=%0d tick=%b wrap=%b expected 0/0/0", current_number, tick, wrap);
        end
        @(negedge CLOCK_50);
        resetn = 1'b1;
    endtask

    // Speed 0 with a one-cycle period steps on every edge, starting with the
    // first edge after reset release.
    task automatic test_count_up();
        for (int k = 1; k <= 102; k++) begin
            cycle();
            assertCount++;
            if (current_number !== 7'(k % 101)) begin
                failCount++;
                $display("[TB] FAIL up_count k=%0d: cur=%0d expected %0d", k, current_number, k % 101);
            end
            assertCount++;
            if (tick !== 1'b1) begin
                failCount++;
                $display("[TB] FAIL up_tick k=%0d: tick=%b expected 1", k, tick);
            end
            assertCount++;
            if (wrap !== (k == 101)) begin
                failCount++;
                $display("[TB] FAIL up_wrap k=%0d: wrap=%b expected %b", k, wrap, (k == 101));
            end
        end
    endtask

    // Speed 1 (period 4), counting down from a loaded 2.
    task automatic test_count_down();
        int expCur;
        clk_speed = 3'd1; dir = 1'b1; load = 1'b1; load_value = 7'd2;
        cycle();
        load = 1'b0;
        assertCount++;
        if (current_number !== 7'd2 || tick !== 1'b0 || wrap !== 1'b0) begin
            failCount++;
            $display("[TB] FAIL down_change: cur=%0d tick=%b wrap=%b expected 2/0/0", current_number, tick, wrap);
        end
        for (int j = 1; j <= 16; j++) begin
            cycle();
            expCur = (j < 4) ? 2 : (j < 8) ? 1 : (j < 12) ? 0 : (j < 16) ? 100 : 99;
            assertCount++;
            if (current_number !== 7'(expCur)) begin
                failCount++;
                $display("[TB] FAIL down_count j=%0d: cur=%0d expected %0d", j, current_number, expCur);
            end
            assertCount++;
            if (tick !== (j % 4 == 0)) begin
                failCount++;
                $display("[TB] FAIL down_tick j=%0d: tick=%b expected %b", j, tick, (j % 4 == 0));
            end
            assertCount++;
            if (wrap !== (j == 12)) begin
                failCount++;
                $display("[TB] FAIL down_wrap j=%0d: wrap=%b expected %b", j, wrap, (j == 12));
            end
        end
    endtask

    // Load clamping, and a load that lands on a step which would otherwise wrap.
    task automatic test_load_clamp();
        load = 1'b1; load_value = 7'd120;
        cycle();
        load = 1'b0; dir = 1'b0;
        assertCount++;
        if (current_number !== 7'd100 || wrap !== 1'b0 || tick !== 1'b0) begin
            failCount++;
            $display("[TB] FAIL load_clamp: cur=%0d tick=%b wrap=%b expected 100/0/0", current_number, tick, wrap);
        end
        for (int i = 0; i < 2; i++) begin
            cycle();
            assertCount++;
            if (current_number !== 7'd100 || tick !== 1'b0) begin
                failCount++;
                $display("[TB] FAIL load_wait i=%0d: cur=%0d tick=%b expected 100/0", i, current_number, tick);
            end
        end
        load = 1'b1; load_value = 7'd5;
        cycle();
        load = 1'b0;
        assertCount++;
        if (current_number !== 7'd5 || tick !== 1'b1 || wrap !== 1'b0) begin
            failCount++;
            $display("[TB] FAIL load_on_step: cur=%0d tick=%b wrap=%b expected 5/1/0", current_number, tick, wrap);
        end
    endtask

    // Pause mid-period. After resuming, the step comes after the remaining 3 cycles.
    task automatic test_pause();
        cycle();
        run = 1'b0;
        for (int i = 0; i < 10; i++) begin
            cycle();
            assertCount++;
            if (tick !== 1'b0 || current_number !== 7'd5) begin
                failCount++;
                $display("[TB] FAIL pause_hold i=%0d: cur=%0d tick=%b expected 5/0", i, current_number, tick);
            end
        end
        run = 1'b1;
        for (int i = 1; i <= 3; i++) begin
            cycle();
            assertCount++;
            if (tick !== (i == 3) || current_number !== ((i == 3) ? 7'd6 : 7'd5)) begin
                failCount++;
                $display("[TB] FAIL pause_resume i=%0d: cur=%0d tick=%b expected %0d/%b",
                         i, current_number, tick, (i == 3) ? 6 : 5, (i == 3));
            end
        end
    endtask

    // Switch from speed 1 to speed 2 (period 6) mid-period, then to invalid select 6.
    task automatic test_speed_change();
        cycle();
        clk_speed = 3'd2;
        cycle();
        assertCount++;
        if (tick !== 1'b0 || current_number !== 7'd6) begin
            failCount++;
            $display("[TB] FAIL speed_change_cycle: cur=%0d tick=%b expected 6/0", current_number, tick);
        end
        for (int i = 1; i <= 6; i++) begin
            cycle();
            assertCount++;
            if (tick !== (i == 6) || current_number !== ((i == 6) ? 7'd7 : 7'd6)) begin
                failCount++;
                $display("[TB] FAIL speed2_step i=%0d: cur=%0d tick=%b expected %0d/%b",
                         i, current_number, tick, (i == 6) ? 7 : 6, (i == 6));
            end
        end
        clk_speed = 3'd6;
        for (int i = 0; i < 11; i++) begin
            cycle();
            assertCount++;
            if (tick !== 1'b0 || current_number !== 7'd7) begin
                failCount++;
                $display("[TB] FAIL invalid_sel i=%0d: cur=%0d tick=%b expected 7/0", i, current_number, tick);
            end
        end
    endtask

    // Asynchronous reset pulse at count 57, then a restart from 0.
    task automatic test_async_reset();
        clk_speed = 3'd0; load = 1'b1; load_value = 7'd56;
        cycle();
        load = 1'b0;
        cycle();
        assertCount++;
        if (current_number !== 7'd57 || tick !== 1'b1) begin
            failCount++;
            $display("[TB] FAIL pre_reset: cur=%0d tick=%b expected 57/1", current_number, tick);
        end
        #2 resetn = 1'b0;
        #1;
        assertCount++;
        if (current_number !== 7'd0 || tick !== 1'b0 || wrap !== 1'b0) begin
            failCount++;
            $display("[TB] FAIL midcount_reset: cur=%0d tick=%b wrap=%b expected 0/0/0", current_number, tick, wrap);
        end
        @(negedge CLOCK_50);
        resetn = 1'b1;
        for (int k = 1; k <= 3; k++) begin
            cycle();
            assertCount++;
            if (current_number !== 7'(k) || tick !== 1'b1) begin
                failCount++;
                $display("[TB] FAIL restart k=%0d: cur=%0d tick=%b expected %0d/1", k, current_number, tick, k);
            end
        end
    endtask

    initial begin
        test_reset();
        test_count_up();
        test_count_down();
        test_load_clamp();
        test_pause();
        test_speed_change();
        test_async_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

    // Watchdog that stops the run if the sequence above never completes.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] timeout");
    end

endmodule
